// File: rtl/uart_tx_pkg.sv
// ============================================================================
// Module   : uart_tx_pkg
// Desc     : Shared states and frame constants for the CTS-gated UART transmitter.
// Options  : UART_TX_PARITY_EN selects the 11-bit (8E1) frame length.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_tx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        STOP   = 3'd3,
        PARITY = 3'd4
    } uart_tx_state_e;

    localparam int   UART_DATA_BITS  = 8;
`ifdef UART_TX_PARITY_EN
    localparam int   UART_FRAME_BITS = 11;
`else
    localparam int   UART_FRAME_BITS = 10;
`endif
    localparam logic UART_IDLE_LEVEL = 1'b1;

    // A zero divisor would stall the bit counter, so it runs at one clock per bit.
    function automatic logic [15:0] eff_divisor(input logic [15:0] divisor);
        return (divisor == 16'd0) ? 16'd1 : divisor;
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_tx_fifo.sv
// ============================================================================
// Module   : uart_tx_fifo
// Desc     : Synchronous power-of-two FIFO; pushes are dropped while full and
//            pops are ignored while empty.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_fifo
    import uart_tx_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int c_ADDR_W = $clog2(DEPTH);

    logic [WIDTH-1:0]    r_mem [DEPTH];
    logic [c_ADDR_W-1:0] r_wr_ptr;
    logic [c_ADDR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0]    r_count;
    logic                w_do_push;
    logic                w_do_pop;

    assign full      = (r_count == CNT_W'(DEPTH));
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign pop_data  = r_mem[r_rd_ptr];
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage carries no reset so it can map onto distributed RAM.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

endmodule

`default_nettype wire

// File: rtl/uart_tx_fc.sv
// ============================================================================
// Module   : uart_tx_fc
// Desc     : FIFO-buffered 8N1 UART transmitter; CTS is sampled only when a
//            frame starts, so a frame in flight always completes.
// Options  : UART_TX_PARITY_EN inserts an even-parity bit (8E1).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_fc
    import uart_tx_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    input  logic [15:0]      baud_divisor,
    input  logic             uart_cts_n,
    output logic             uart_tx,
    output logic             tx_busy,
    output logic             byte_transmitted,
    output logic [CNT_W-1:0] fifo_count
);

    uart_tx_state_e r_state;
    uart_tx_state_e w_state_next;
    logic           r_cts_meta;
    logic           r_cts_sync;
    logic           w_cts_ok;
    logic [7:0]     r_shift;
    logic [7:0]     w_shift_next;
    logic [15:0]    r_div;
    logic [15:0]    w_div_next;
    logic [15:0]    r_bit_cnt;
    logic [15:0]    w_bit_cnt_next;
    logic [2:0]     r_bit_idx;
    logic [2:0]     w_bit_idx_next;
    logic           r_tx;
    logic           w_tx_next;
    logic           w_bit_end;
    logic           w_can_start;
    logic           w_load;
    logic [15:0]    w_eff_div;
    logic           w_pop;
    logic [7:0]     w_fifo_head;
    logic           w_fifo_full;
    logic           w_fifo_empty;
`ifdef UART_TX_PARITY_EN
    logic           r_parity;
    logic           w_parity_next;
`endif

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (UART_DATA_BITS),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (tx_valid),
        .push_data (tx_data),
        .pop       (w_pop),
        .pop_data  (w_fifo_head),
        .full      (w_fifo_full),
        .empty     (w_fifo_empty),
        .count     (fifo_count)
    );

    assign tx_ready         = !w_fifo_full;
    assign uart_tx          = r_tx;
    assign tx_busy          = (r_state != IDLE) || !w_fifo_empty;
    assign byte_transmitted = (r_state == STOP) && w_bit_end;

    assign w_cts_ok    = !r_cts_sync;
    assign w_bit_end   = (r_bit_cnt == 16'd0);
    assign w_can_start = !w_fifo_empty && w_cts_ok;
    assign w_eff_div   = eff_divisor(baud_divisor);

    always_comb begin
        w_state_next   = r_state;
        w_shift_next   = r_shift;
        w_div_next     = r_div;
        w_bit_cnt_next = r_bit_cnt;
        w_bit_idx_next = r_bit_idx;
        w_load         = 1'b0;
        w_pop          = 1'b0;
`ifdef UART_TX_PARITY_EN
        w_parity_next  = r_parity;
`endif

        case (r_state)
            IDLE: begin
                w_load = w_can_start;
            end
            START: begin
                if (w_bit_end) begin
                    w_state_next   = DATA;
                    w_bit_cnt_next = r_div - 16'd1;
                end else begin
                    w_bit_cnt_next = r_bit_cnt - 16'd1;
                end
            end
            DATA: begin
                if (w_bit_end) begin
                    w_bit_cnt_next = r_div - 16'd1;
                    if (r_bit_idx == 3'(UART_DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
                        w_state_next = PARITY;
`else
                        w_state_next = STOP;
`endif
                    end else begin
                        w_bit_idx_next = r_bit_idx + 3'd1;
                        w_shift_next   = {1'b0, r_shift[7:1]};
                    end
                end else begin
                    w_bit_cnt_next = r_bit_cnt - 16'd1;
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (w_bit_end) begin
                    w_state_next   = STOP;
                    w_bit_cnt_next = r_div - 16'd1;
                end else begin
                    w_bit_cnt_next = r_bit_cnt - 16'd1;
                end
            end
`endif
            STOP: begin
                if (w_bit_end) begin
                    // Chain straight into the next start bit when a byte is ready.
                    if (w_can_start) begin
                        w_load = 1'b1;
                    end else begin
                        w_state_next = IDLE;
                    end
                end else begin
                    w_bit_cnt_next = r_bit_cnt - 16'd1;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase

        if (w_load) begin
            w_state_next   = START;
            w_pop          = 1'b1;
            w_shift_next   = w_fifo_head;
            w_div_next     = w_eff_div;
            w_bit_cnt_next = w_eff_div - 16'd1;
            w_bit_idx_next = 3'd0;
`ifdef UART_TX_PARITY_EN
            w_parity_next  = ^w_fifo_head;
`endif
        end

        // Line level follows the upcoming state so the pin is a clean flop output.
        case (w_state_next)
            START:   w_tx_next = 1'b0;
            DATA:    w_tx_next = w_shift_next[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  w_tx_next = w_parity_next;
`endif
            default: w_tx_next = UART_IDLE_LEVEL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cts_meta <= 1'b1;
            r_cts_sync <= 1'b1;
        end else begin
            r_cts_meta <= uart_cts_n;
            r_cts_sync <= r_cts_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_shift   <= 8'd0;
            r_div     <= 16'd1;
            r_bit_cnt <= 16'd0;
            r_bit_idx <= 3'd0;
            r_tx      <= UART_IDLE_LEVEL;
`ifdef UART_TX_PARITY_EN
            r_parity  <= 1'b0;
`endif
        end else begin
            r_state   <= w_state_next;
            r_shift   <= w_shift_next;
            r_div     <= w_div_next;
            r_bit_cnt <= w_bit_cnt_next;
            r_bit_idx <= w_bit_idx_next;
            r_tx      <= w_tx_next;
`ifdef UART_TX_PARITY_EN
            r_parity  <= w_parity_next;
`endif
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_fc.sv
// ============================================================================
// Module   : tb_uart_tx_fc
// Desc     : Directed self-checking bench for uart_tx_fc (default 8N1 build).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_fc;

    localparam int FIFO_DEPTH = 16;
    localparam int CNT_W      = 5;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [7:0]       tx_data = 8'h00;
    logic             tx_valid = 1'b0;
    logic             tx_ready;
    logic [15:0]      baud_divisor = 16'd4;
    logic             uart_cts_n = 1'b0;
    logic             uart_tx;
    logic             tx_busy;
    logic             byte_transmitted;
    logic [CNT_W-1:0] fifo_count;

    int n_checks = 0;
    int n_fail   = 0;

    uart_tx_fc #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .CNT_W      (CNT_W)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .tx_data          (tx_data),
        .tx_valid         (tx_valid),
        .tx_ready         (tx_ready),
        .baud_divisor     (baud_divisor),
        .uart_cts_n       (uart_cts_n),
        .uart_tx          (uart_tx),
        .tx_busy          (tx_busy),
        .byte_transmitted (byte_transmitted),
        .fifo_count       (fifo_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected TB_RESULT before 200000");
        $fatal(1);
    end

    task automatic check_value(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic push_byte(input logic [7:0] b, output logic acc);
        @(negedge clk);
        tx_data  = b;
        tx_valid = 1'b1;
        acc      = tx_ready;
        @(posedge clk);
        #1 tx_valid = 1'b0;
    endtask

    task automatic wait_start(input int bound, output int cycles);
        cycles = 0;
        for (int i = 1; i <= bound; i++) begin
            @(negedge clk);
            if (uart_tx === 1'b0) begin
                cycles = i;
                break;
            end
        end
        check_value("start_seen", 32'(cycles != 0), 32'd1);
    endtask

    // Entered on the negedge of the first start-bit clock; leaves on the last stop clock.
    task automatic recv_frame(input logic [7:0] b, input int div, input string tag);
        logic [9:0] bits;
        int bit_err;
        int bt_err;
        bits    = {1'b1, b, 1'b0};
        bit_err = 0;
        bt_err  = 0;
        for (int k = 0; k < 10 * div; k++) begin
            if (k > 0) @(negedge clk);
            if (uart_tx !== bits[k / div]) bit_err++;
            if (tx_busy !== 1'b1) bit_err++;
            if (byte_transmitted !== (k == 10 * div - 1)) bt_err++;
        end
        check_value({tag, "_bits"}, bit_err, 0);
        check_value({tag, "_pulse"}, bt_err, 0);
    endtask

    initial begin
        logic       acc;
        logic       acc2;
        logic [7:0] b;
        int         cyc;
        int         errs;
        int         n_acc;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_value("rst_tx", uart_tx, 1);
        check_value("rst_busy", tx_busy, 0);
        check_value("rst_bt", byte_transmitted, 0);
        check_value("rst_count", fifo_count, 0);
        check_value("rst_ready", tx_ready, 1);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Basic frame, divisor 4.
        push_byte(8'hA5, acc);
        check_value("basic_acc", acc, 1);
        @(negedge clk);
        check_value("basic_latency_idle", uart_tx, 1);
        @(negedge clk);
        recv_frame(8'hA5, 4, "basic");
        @(negedge clk);
        check_value("basic_busy_fall", tx_busy, 0);
        check_value("basic_bt_after", byte_transmitted, 0);

        // Flow control hold and release.
        uart_cts_n = 1'b1;
        repeat (3) @(negedge clk);
        push_byte(8'h55, acc);
        errs = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (uart_tx !== 1'b1 || tx_busy !== 1'b1 || fifo_count !== 5'd1) errs++;
        end
        check_value("cts_hold", errs, 0);
        uart_cts_n = 1'b0;
        wait_start(6, cyc);
        check_value("cts_latency", cyc, 3);
        fork
            recv_frame(8'h55, 4, "cts_frame");
            begin
                repeat (8) @(negedge clk);
                uart_cts_n = 1'b1;
                push_byte(8'h96, acc2);
            end
        join
        check_value("cts_second_acc", acc2, 1);
        errs = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (uart_tx !== 1'b1 || fifo_count !== 5'd1) errs++;
        end
        check_value("cts_second_held", errs, 0);
        uart_cts_n = 1'b0;
        wait_start(6, cyc);
        check_value("cts_release_latency", cyc, 3);
        recv_frame(8'h96, 4, "cts_held_frame");

        // Back-to-back, divisor 2: frames at clocks 1-20, 21-40, 41-60.
        @(negedge clk);
        baud_divisor = 16'd2;
        fork
            begin
                push_byte(8'h00, acc);
                push_byte(8'hFF, acc);
                push_byte(8'h3C, acc);
            end
            begin
                wait_start(8, cyc);
                recv_frame(8'h00, 2, "b2b0");
                @(negedge clk);
                recv_frame(8'hFF, 2, "b2b1");
                @(negedge clk);
                recv_frame(8'h3C, 2, "b2b2");
            end
        join
        @(negedge clk);
        check_value("b2b_busy_fall", tx_busy, 0);

        // FIFO full with CTS held off.
        uart_cts_n = 1'b1;
        repeat (3) @(negedge clk);
        n_acc = 0;
        errs  = 0;
        for (int i = 0; i < 17; i++) begin
            b = 8'h20 + 8'(i);
            push_byte(b, acc);
            if (acc) n_acc++;
            if (acc !== (i < 16)) errs++;
        end
        check_value("full_ready_seq", errs, 0);
        check_value("full_accepted", n_acc, 16);
        @(negedge clk);
        check_value("full_count", fifo_count, 16);
        check_value("full_ready", tx_ready, 0);
        uart_cts_n = 1'b0;
        wait_start(6, cyc);
        for (int i = 0; i < 16; i++) begin
            if (i > 0) @(negedge clk);
            b = 8'h20 + 8'(i);
            recv_frame(b, 2, $sformatf("full_frame%0d", i));
        end
        @(negedge clk);
        check_value("full_drained_count", fifo_count, 0);
        check_value("full_drained_busy", tx_busy, 0);

        // Divisor 0 runs at one clock per bit.
        baud_divisor = 16'd0;
        push_byte(8'h3A, acc);
        wait_start(4, cyc);
        recv_frame(8'h3A, 1, "div0");

        // Divisor change mid-frame applies to the next frame only.
        @(negedge clk);
        baud_divisor = 16'd4;
        push_byte(8'hC3, acc);
        push_byte(8'h5A, acc);
        wait_start(4, cyc);
        fork
            recv_frame(8'hC3, 4, "div4");
            begin
                repeat (10) @(negedge clk);
                baud_divisor = 16'd8;
            end
        join
        @(negedge clk);
        recv_frame(8'h5A, 8, "div8");

        // Reset during DATA with a second byte queued.
        @(negedge clk);
        baud_divisor = 16'd4;
        push_byte(8'hF0, acc);
        wait_start(4, cyc);
        repeat (8) @(negedge clk);
        push_byte(8'h11, acc);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_value("rst_mid_tx", uart_tx, 1);
        check_value("rst_mid_count", fifo_count, 0);
        check_value("rst_mid_busy", tx_busy, 0);
        errs = 0;
        cyc  = 0;
        for (int i = 0; i < 40; i++) begin
            if (byte_transmitted !== 1'b0) cyc++;
            if (uart_tx !== 1'b1) errs++;
            @(negedge clk);
        end
        check_value("rst_mid_no_pulse", cyc, 0);
        check_value("rst_mid_line_idle", errs, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/uart_tx_fc.md
Name: uart_tx_fc

Overview:
- Byte-stream UART transmitter with CTS hardware flow control; the transmit end of the bridge's UART link, driving uart_tx with the uart_cts_n handshake.
- Accepts bytes over a valid/ready port into a small synchronous FIFO and serialises them 8N1, LSB first.
- Bit period is set by a runtime baud_divisor.
- Supplies tx_busy and byte_transmitted for system status and UVM monitoring.

Parameters:
- FIFO_DEPTH, 16, transmit FIFO entries; power of two, at least 2.
- CNT_W, $clog2(FIFO_DEPTH)+1, width of fifo_count.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- tx_data  in  8  byte to send
- tx_valid  in  1  tx_data valid
- tx_ready  out  1  FIFO can accept a byte
- baud_divisor  in  16  clocks per bit
- uart_cts_n  in  1  clear-to-send from far end, active low, asynchronous
- uart_tx  out  1  serial output, idle high
- tx_busy  out  1  FIFO non-empty or frame in progress
- byte_transmitted  out  1  one-cycle pulse at end of each frame
- fifo_count  out  CNT_W  bytes currently queued

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-low (rst_n).
- Reset values:
  - uart_tx=1, tx_busy=0, byte_transmitted=0, fifo_count=0, tx_ready=1.
  - FSM in IDLE; CTS synchroniser flops = 1 (not clear).
- Reset mid-frame: the frame is aborted, uart_tx=1 on the next cycle, and the FIFO is flushed.
- Push handshake:
  - A byte is written on a clock edge where tx_valid && tx_ready.
  - tx_ready = (fifo_count != FIFO_DEPTH), combinational from registered count.
  - When full, no write occurs even if a pop happens in the same cycle.
  - Simultaneous push and pop when not full: count is unchanged.
- CTS input: uart_cts_n passes through a 2-FF synchroniser; cts_ok = !synchronised value.
- FSM states: IDLE, START, DATA, STOP.
- IDLE:
  - Moves to START if the FIFO is non-empty and cts_ok.
  - On that edge: pop the head byte into the shift register, and latch div = max(baud_divisor,1).
  - Timing: a byte written at edge E0 into an empty FIFO, with cts_ok already high, drives uart_tx low after E0+1.
- START: uart_tx=0 for div clocks, then DATA.
- DATA: 8 bits, LSB first, each held div clocks; bit index 0..7; after bit 7 go to STOP.
- STOP: uart_tx=1 for div clocks.
  - byte_transmitted pulses high during the last STOP clock.
  - At STOP end, the same IDLE condition is evaluated. If it is true, go directly to START with no idle gap (back-to-back frames). Otherwise go to IDLE.
- Frame length: exactly 10*div clocks.
- CTS is checked only at frame start. Deasserting it mid-frame never truncates the frame; the next frame is held.
- baud_divisor changes take effect only at the next frame start. A divisor of 0 is treated as 1.
- Bit counter is 16 bits; it reloads at each bit boundary with no wrap hazard.
- tx_busy = (state != IDLE) || (fifo_count != 0).

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- When defined:
  - A PARITY state is inserted between DATA and STOP.
  - uart_tx = even parity (XOR of the 8 data bits) for div clocks.
  - Frame length becomes 11*div clocks.
- When undefined: pure 8N1 at 10*div clocks; no PARITY state or logic is present.

Decomposition:
- Package uart_tx_pkg holds:
  - the state enum uart_tx_state_e (IDLE, START, DATA, STOP, PARITY);
  - localparams UART_DATA_BITS=8 and UART_FRAME_BITS (10, or 11 with parity);
  - UART_IDLE_LEVEL=1'b1.
- Sub-module uart_tx_fifo: a generic synchronous FIFO with push, pop, full, empty and count, using the same clock and reset. The FSM, synchroniser and shifter stay in uart_tx_fc.

Test Plan:
- Basic frame: baud_divisor=4, cts_n=0, write 0xA5.
  - uart_tx low 4 clocks, then 1,0,1,0,0,1,0,1 at 4 clocks each, then high 4 clocks (40 clocks total).
  - byte_transmitted pulses at clock 40; tx_busy falls on the next cycle.
- Flow control hold: cts_n=1, write 0x55.
  - uart_tx stays 1 for 100 clocks with tx_busy=1 and fifo_count=1.
  - Drop cts_n to 0: start bit begins within 3 clocks.
  - Raise cts_n mid-frame: the frame completes and a queued second byte is held.
- Back-to-back: baud_divisor=2, write 0x00, 0xFF, 0x3C.
  - 60 contiguous clocks with no idle between stop and start bits.
  - Three byte_transmitted pulses at clocks 20, 40 and 60.
- FIFO full: cts_n=1, write 17 bytes.
  - tx_ready low after the 16th; fifo_count=16; the 17th is not accepted.
  - Release CTS: exactly 16 frames are sent in order.
- Divisor edges: baud_divisor=0 gives 1 clock per bit (10-clock frame). Changing 4→8 mid-frame leaves the current frame at 4 and the next at 8.
- Reset mid-DATA: assert rst_n=0 for one edge. uart_tx=1, fifo_count=0 and tx_busy=0 on the next cycle, and no byte_transmitted pulse occurs.
